// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counting primitives in the FSM/logic library.
//   - CNT_UP / CNT_DOWN : encodings for the 'up' direction input.
//   - clog2()           : bits needed to hold the values 0..value-1, so a
//                         caller can size WIDTH from a chosen MODULUS.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Constant function; clog2(1) = 0, clog2(10) = 4, clog2(16) = 4.
  function automatic int clog2(input longint value);
    int     bits;
    longint v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >>> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_nbit_mod.sv
// counter_nbit_mod
//   Parametrised, cascadable, synchronous modulo-MODULUS up/down counter.
//   Counts 0..MODULUS-1, wraps in either direction, supports a clamped
//   parallel load and keeps a sticky wrap flag.
//
// Parameters
//   WIDTH    counter width, 1..32
//   MODULUS  count range 0..MODULUS-1, 2..2**WIDTH
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset (clears q and ovf)
//   en       count enable, shared by every stage of a chain
//   ci       carry-in; tie to 1 on the first (or only) stage
//   up       1 = count up, 0 = count down
//   load     synchronous parallel load, beats counting
//   d        load value; values >= MODULUS load MODULUS-1
//   clr_ovf  synchronous clear of ovf (a simultaneous wrap wins)
//   q        registered count
//   rc       combinational ripple carry/borrow; drive next stage's ci
//   ovf      registered sticky wrap flag
//
// Chaining: next.ci = this.rc, en shared. rc is combinational so every stage
// of a chain steps on the same edge.
module counter_nbit_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             rc,
  output logic             ovf
);

  // Parameter legality is enforced at elaboration time.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_nbit_mod: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("counter_nbit_mod: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  // Full-range modulus: every code is legal and the binary wrap is free.
  localparam bit FULL = (MODULUS == (longint'(1) << WIDTH));

  logic             step;      // a count step happens on the next edge
  logic             tc;        // terminal count in the current direction
  logic             illegal;   // q outside 0..MODULUS-1
  logic [WIDTH-1:0] d_clamped;

  if (FULL) begin : g_full
    assign illegal   = 1'b0;
    assign d_clamped = d;
  end else begin : g_partial
    assign illegal   = (q > MAXV);
    assign d_clamped = (d > MAXV) ? MAXV : d;
  end

  assign step = ~load & en & ci;
  assign tc   = (up == CNT_UP) ? (q == MAXV) : (q == '0);
  assign rc   = step & tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d_clamped;
    end else if (step) begin
      // An out-of-range value (glitch/X recovery) snaps back to zero.
      if (illegal) begin
        q <= '0;
      end else if (up == CNT_UP) begin
        q <= tc ? '0 : q + 1'b1;
      end else begin
        q <= tc ? MAXV : q - 1'b1;
      end
    end
  end

  // Set on a wrap; a wrap on the same edge as clr_ovf leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (step && tc) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_nbit_mod.sv
// Bench for counter_nbit_mod: a BCD two-digit cascade (ones/tens, MODULUS 10)
// plus an independent full-range binary instance (WIDTH 4, MODULUS 16).
// A reference model of integers with modulo arithmetic predicts every output.
module tb_counter_nbit_mod;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       en, up;
  logic       o_ci, o_load, o_clr;
  logic [3:0] o_d;
  logic       t_load, t_clr;
  logic [3:0] t_d;
  logic       b_en, b_ci, b_up, b_load, b_clr;
  logic [3:0] b_d;

  logic [3:0] o_q, t_q, b_q;
  logic       o_rc, t_rc, b_rc;
  logic       o_ovf, t_ovf, b_ovf;

  counter_nbit_mod #(.WIDTH(4), .MODULUS(10)) u_ones (
    .clk(clk), .rst(rst), .en(en), .ci(o_ci), .up(up), .load(o_load),
    .d(o_d), .clr_ovf(o_clr), .q(o_q), .rc(o_rc), .ovf(o_ovf)
  );

  counter_nbit_mod #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .rst(rst), .en(en), .ci(o_rc), .up(up), .load(t_load),
    .d(t_d), .clr_ovf(t_clr), .q(t_q), .rc(t_rc), .ovf(t_ovf)
  );

  counter_nbit_mod #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk(clk), .rst(rst), .en(b_en), .ci(b_ci), .up(b_up), .load(b_load),
    .d(b_d), .clr_ovf(b_clr), .q(b_q), .rc(b_rc), .ovf(b_ovf)
  );

  // ---------------- reference model ----------------
  // index 0 = ones, 1 = tens, 2 = bin
  int mq[3];
  bit movf[3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  function automatic bit rc_of(int qv, int m, bit e, bit c, bit u, bit ld);
    bit at_end;
    at_end = u ? (qv == m - 1) : (qv == 0);
    return e & c & ~ld & at_end;
  endfunction

  // Next state of one counter following the behavioural rules directly.
  function automatic void model_next(int i, int m, bit e, bit c, bit u,
                                     bit ld, int dv, bit clr);
    bit wrap;
    wrap = 1'b0;
    if (ld) begin
      mq[i] = (dv >= m) ? m - 1 : dv;
    end else if (e && c) begin
      wrap = u ? (mq[i] == m - 1) : (mq[i] == 0);
      if (mq[i] >= m)  mq[i] = 0;
      else if (u)      mq[i] = (mq[i] + 1) % m;
      else             mq[i] = (mq[i] + m - 1) % m;
    end
    if (wrap)     movf[i] = 1'b1;
    else if (clr) movf[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i]   = 0;
      movf[i] = 1'b0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    bit ones_rc;
    ones_rc = rc_of(mq[0], 10, en, o_ci, up, o_load);
    chk("ones_q",   32'(o_q),   32'(mq[0]));
    chk("ones_ovf", 32'(o_ovf), 32'(movf[0]));
    chk("ones_rc",  32'(o_rc),  32'(ones_rc));
    chk("tens_q",   32'(t_q),   32'(mq[1]));
    chk("tens_ovf", 32'(t_ovf), 32'(movf[1]));
    chk("tens_rc",  32'(t_rc),  32'(rc_of(mq[1], 10, en, ones_rc, up, t_load)));
    chk("bin_q",    32'(b_q),   32'(mq[2]));
    chk("bin_ovf",  32'(b_ovf), 32'(movf[2]));
    chk("bin_rc",   32'(b_rc),  32'(rc_of(mq[2], 16, b_en, b_ci, b_up, b_load)));
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: predict, wait for the edge, check 1 time unit later.
  task automatic tick();
    bit ones_rc;
    ones_rc = rc_of(mq[0], 10, en, o_ci, up, o_load);
    if (rst) begin
      model_reset();
    end else begin
      model_next(0, 10, en, o_ci, up, o_load, int'(o_d), o_clr);
      model_next(1, 10, en, ones_rc, up, t_load, int'(t_d), t_clr);
      model_next(2, 16, b_en, b_ci, b_up, b_load, int'(b_d), b_clr);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Assert reset in the middle of a cycle and confirm it acts at once.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic load_ones(input logic [3:0] v);
    o_load = 1'b1;
    o_d    = v;
    tick();
    o_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en = 1'b1; up = 1'b1;
    o_ci = 1'b1; o_load = 1'b0; o_clr = 1'b0; o_d = '0;
    t_load = 1'b0; t_clr = 1'b0; t_d = '0;
    b_en = 1'b0; b_ci = 1'b1; b_up = 1'b1; b_load = 1'b0; b_clr = 1'b0; b_d = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // 1. count to 7, then reset mid-cycle and hold it
    ticks(7);
    chk("ones_at_7", 32'(o_q), 32'd7);
    async_reset();
    ticks(2);
    rst = 1'b0;

    // 2. BCD up-wrap with the ordered expected sequence
    for (int v = 1; v <= 10; v++) exp_q.push_back(32'(v % 10));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bcd_seq", 32'(o_q), exp_q.pop_front());
    end
    chk("bcd_wrap_ovf", 32'(o_ovf), 32'd1);
    o_clr = 1'b1;
    tick();
    o_clr = 1'b0;
    chk("ovf_cleared", 32'(o_ovf), 32'd0);
    ticks(8);
    chk("ones_at_9", 32'(o_q), 32'd9);
    o_clr = 1'b1;
    tick();
    o_clr = 1'b0;
    chk("clr_vs_wrap", 32'(o_ovf), 32'd1);

    // 3. down-count through 0, then flip direction at 8
    load_ones(4'd2);
    up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check_all();
      tick();
    end
    chk("down_at_8", 32'(o_q), 32'd8);
    up = 1'b1;
    #1 check_all();
    tick();
    chk("flip_rc", 32'(o_rc), 32'd1);

    // 4. load priority and clamp
    load_ones(4'd5);
    chk("load_5", 32'(o_q), 32'd5);
    o_clr = 1'b1; tick(); o_clr = 1'b0;
    load_ones(4'd13);
    chk("load_clamp", 32'(o_q), 32'd9);
    chk("load_no_ovf", 32'(o_ovf), 32'd0);
    o_load = 1'b1; o_d = 4'd9;
    #1 check_all();
    chk("load_masks_rc", 32'(o_rc), 32'd0);
    o_load = 1'b0;

    // 5. enable and carry-in hold
    load_ones(4'd4);
    en = 1'b0;
    ticks(3);
    en = 1'b1; o_ci = 1'b0;
    ticks(3);
    chk("hold_q", 32'(o_q), 32'd4);
    o_ci = 1'b1;

    // 6. two-digit cascade 00 -> 99 -> 00
    async_reset();
    tick();
    rst = 1'b0;
    ticks(99);
    chk("cascade_99", 32'(t_q * 10 + o_q), 32'd99);
    chk("tens_rc_99", 32'(t_rc), 32'd1);
    tick();
    chk("cascade_00", 32'(t_q * 10 + o_q), 32'd0);
    chk("tens_ovf", 32'(t_ovf), 32'd1);

    // 7. randomized traffic on all three counters
    for (int k = 0; k < 400; k++) begin
      en     = 1'($urandom_range(0, 3) != 0);
      up     = 1'($urandom_range(0, 1));
      o_ci   = 1'($urandom_range(0, 4) != 0);
      o_load = 1'($urandom_range(0, 7) == 0);
      o_d    = 4'($urandom_range(0, 15));
      o_clr  = 1'($urandom_range(0, 5) == 0);
      t_load = 1'($urandom_range(0, 15) == 0);
      t_d    = 4'($urandom_range(0, 15));
      t_clr  = 1'($urandom_range(0, 5) == 0);
      b_en   = 1'($urandom_range(0, 3) != 0);
      b_ci   = 1'($urandom_range(0, 3) != 0);
      b_up   = 1'($urandom_range(0, 1));
      b_load = 1'($urandom_range(0, 7) == 0);
      b_d    = 4'($urandom_range(0, 15));
      b_clr  = 1'($urandom_range(0, 5) == 0);
      #1 check_all();
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
